// File: rtl/mul_approx_seq.sv
// Sequential shift-add multiplier with a runtime exact/approximate mode.
// Approximate mode drops partial-product bits below column TRUNC, optionally adding a fixed compensation.
module mul_approx_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TRUNC = 4,
   parameter int unsigned COMP  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_approx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_approx
);

   localparam int unsigned PW      = 2 * WIDTH;
   localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned COMP_SH = (TRUNC > 0) ? TRUNC - 1 : 0;
   localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << TRUNC) - PW'(1));
   localparam logic [PW-1:0] COMP_VAL  = (COMP != 0 && TRUNC > 0) ? (PW'(1) << COMP_SH) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic             approx_q;
   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    acc_q;
   logic             accept, last;
   logic [PW-1:0]    pp;
   logic [PW:0]      sum;

   assign in_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // One extra carry bit so the compensated sum can be saturated instead of wrapping.
   always_comb begin
      pp = '0;
      if (b_q[cnt_q]) pp = PW'(a_q) << cnt_q;
      if (approx_q) pp = pp & KEEP_MASK;
      sum = {1'b0, acc_q} + {1'b0, pp} + ((last && approx_q) ? {1'b0, COMP_VAL} : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         approx_q   <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         out_p      <= '0;
         out_approx <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            approx_q <= in_approx;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else if (state_q == ST_BUSY) begin
            acc_q <= sum[PW-1:0];
            if (last) begin
               out_p      <= sum[PW] ? '1 : sum[PW-1:0];
               out_approx <= approx_q;
               out_valid  <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
         if (state_q == ST_DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule
